// File: rtl/multicycle_control.sv
// Control FSM for a multicycle MIPS-subset datapath: sequences fetch/decode/execute/memory/writeback,
// bounds memory waits with a timeout, and keeps sticky halt/illegal/timeout flags plus a retired count.
module multicycle_control #(
  parameter int ALUOP_W     = 6,
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [5:0]         opcode,
  input  logic [5:0]         funct,
  input  logic               mem_ready,
  output logic               pc_write,
  output logic               pc_write_cond,
  output logic               ir_write,
  output logic               iord,
  output logic               mem_read,
  output logic               mem_write,
  output logic               mem_to_reg,
  output logic               reg_write,
  output logic               reg_dst,
  output logic               wri_data_sel,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [1:0]         pc_source,
  output logic [ALUOP_W-1:0] alu_op,
  output logic [2:0]         state,
  output logic               halted,
  output logic               illegal,
  output logic               timeout,
  output logic [CNT_W-1:0]   retired
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5,
    S_ERROR  = 3'd6
  } state_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_JAL  = 6'b000011;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_XORI = 6'b001110;

  localparam logic [5:0] FN_JR   = 6'b001000;
  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_SLT  = 6'b101010;
  localparam logic [5:0] FN_SYS  = 6'b001100;
  localparam logic [5:0] FN_NOOP = 6'b000000;

  localparam logic [ALUOP_W-1:0] ALU_ADD = ALUOP_W'(6'b100000);
  localparam logic [ALUOP_W-1:0] ALU_SUB = ALUOP_W'(6'b100010);
  localparam logic [ALUOP_W-1:0] ALU_XOR = ALUOP_W'(6'b100110);
  localparam logic [ALUOP_W-1:0] ALU_SLT = ALUOP_W'(6'b101010);
  localparam logic [ALUOP_W-1:0] ALU_NOP = ALUOP_W'(6'b101100);

  localparam int WAIT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  state_t            st;
  logic [WAIT_W-1:0] wait_cnt;
  logic [5:0]        op_q;
  logic [5:0]        fn_q;
  logic [5:0]        cur_op;
  logic [5:0]        cur_fn;

  logic is_r, is_lw, is_sw, is_j, is_jal, is_bne, is_xori;
  logic is_jr, is_nop, is_sys, is_sub, is_slt, is_r_alu, is_jump, is_legal;

  // DECODE sees the instruction register directly; later states use the copy captured there
  assign cur_op = (st == S_DECODE) ? opcode : op_q;
  assign cur_fn = (st == S_DECODE) ? funct  : fn_q;

  assign is_r     = (cur_op == OP_R);
  assign is_lw    = (cur_op == OP_LW);
  assign is_sw    = (cur_op == OP_SW);
  assign is_j     = (cur_op == OP_J);
  assign is_jal   = (cur_op == OP_JAL);
  assign is_bne   = (cur_op == OP_BNE);
  assign is_xori  = (cur_op == OP_XORI);
  assign is_jr    = is_r && (cur_fn == FN_JR);
  assign is_nop   = is_r && (cur_fn == FN_NOOP);
  assign is_sys   = is_r && (cur_fn == FN_SYS);
  assign is_sub   = is_r && (cur_fn == FN_SUB);
  assign is_slt   = is_r && (cur_fn == FN_SLT);
  assign is_r_alu = is_r && ((cur_fn == FN_ADD) || (cur_fn == FN_SUB) || (cur_fn == FN_SLT));
  assign is_jump  = is_j || is_jal || is_jr || is_nop;
  assign is_legal = is_jump || is_sys || is_r_alu || is_lw || is_sw || is_bne || is_xori;

  assign state = st;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st       <= S_FETCH;
      wait_cnt <= '0;
      op_q     <= '0;
      fn_q     <= '0;
      retired  <= '0;
      halted   <= 1'b0;
      illegal  <= 1'b0;
      timeout  <= 1'b0;
    end else begin
      case (st)
        // Completion on the last permitted cycle wins over the timeout
        S_FETCH, S_MEM: begin
          if (mem_ready) begin
            wait_cnt <= '0;
            if (st == S_FETCH) begin
              st <= S_DECODE;
            end else if (is_lw) begin
              st <= S_WB;
            end else begin
              st      <= S_FETCH;
              retired <= retired + CNT_W'(1);
            end
          end else if (wait_cnt == WAIT_LAST) begin
            st      <= S_ERROR;
            timeout <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end
        S_DECODE: begin
          op_q <= opcode;
          fn_q <= funct;
          if (is_jump) begin
            st      <= S_FETCH;
            retired <= retired + CNT_W'(1);
          end else if (is_sys) begin
            st     <= S_HALT;
            halted <= 1'b1;
          end else if (!is_legal) begin
            st      <= S_ERROR;
            illegal <= 1'b1;
          end else begin
            st <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (is_bne) begin
            st      <= S_FETCH;
            retired <= retired + CNT_W'(1);
          end else if (is_lw || is_sw) begin
            st <= S_MEM;
          end else begin
            st <= S_WB;
          end
        end
        S_WB: begin
          st      <= S_FETCH;
          retired <= retired + CNT_W'(1);
        end
        S_HALT, S_ERROR: st <= st;
        default: st <= S_ERROR;
      endcase
    end
  end

  // Fetch completion strobes are suppressed while reset is held
  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    ir_write      = 1'b0;
    iord          = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    mem_to_reg    = 1'b0;
    reg_write     = 1'b0;
    reg_dst       = 1'b0;
    wri_data_sel  = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    pc_source     = 2'b00;
    alu_op        = ALU_NOP;
    case (st)
      S_FETCH: begin
        mem_read = 1'b1;
        if (mem_ready && !reset) begin
          ir_write  = 1'b1;
          pc_write  = 1'b1;
          alu_src_b = 2'b01;
          alu_op    = ALU_ADD;
        end
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
        alu_op    = ALU_ADD;
        if (is_j || is_jal) begin
          pc_write  = 1'b1;
          pc_source = 2'b10;
        end
        if (is_jal) reg_write = 1'b1;
        if (is_jr) begin
          pc_write  = 1'b1;
          pc_source = 2'b11;
        end
      end
      S_EXEC: begin
        alu_src_a = 1'b1;
        if (is_r) begin
          alu_op = is_sub ? ALU_SUB : (is_slt ? ALU_SLT : ALU_ADD);
        end else if (is_xori) begin
          alu_src_b = 2'b10;
          alu_op    = ALU_XOR;
        end else if (is_lw || is_sw) begin
          alu_src_b = 2'b10;
          alu_op    = ALU_ADD;
        end else if (is_bne) begin
          alu_op        = ALU_SUB;
          pc_write_cond = 1'b1;
          pc_source     = 2'b01;
        end
      end
      S_MEM: begin
        iord      = 1'b1;
        mem_read  = is_lw;
        mem_write = is_sw;
      end
      S_WB: begin
        reg_write    = 1'b1;
        wri_data_sel = 1'b1;
        reg_dst      = is_r;
        mem_to_reg   = is_lw;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: decode vector table, directed corner sequences,
// and a random instruction stream checked cycle by cycle against an instruction-level model.
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       mem_ready;
  logic       pc_write, pc_write_cond, ir_write, iord, mem_read, mem_write;
  logic       mem_to_reg, reg_write, reg_dst, wri_data_sel, alu_src_a;
  logic [1:0] alu_src_b, pc_source;
  logic [5:0] alu_op;
  logic [2:0] state;
  logic       halted, illegal, timeout;
  logic [3:0] retired;

  multicycle_control #(.ALUOP_W(6), .MEM_TIMEOUT(15), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .ir_write(ir_write), .iord(iord),
    .mem_read(mem_read), .mem_write(mem_write), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
    .reg_dst(reg_dst), .wri_data_sel(wri_data_sel), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .pc_source(pc_source), .alu_op(alu_op), .state(state), .halted(halted), .illegal(illegal),
    .timeout(timeout), .retired(retired)
  );

  always #5 clk = ~clk;

  localparam logic [2:0] F = 3'd0, D = 3'd1, E = 3'd2, M = 3'd3, W = 3'd4, H = 3'd5, ER = 3'd6;
  localparam logic [5:0] A_ADD = 6'b100000, A_SUB = 6'b100010, A_XOR = 6'b100110;
  localparam logic [5:0] A_SLT = 6'b101010, A_NOP = 6'b101100;

  localparam int K_ADD = 0, K_SUB = 1, K_SLT = 2, K_XORI = 3, K_LW = 4, K_SW = 5, K_J = 6;
  localparam int K_JAL = 7, K_JR = 8, K_NOOP = 9, K_BNE = 10, K_SYS = 11, K_ILL = 12;

  int n_checks = 0;
  int n_pass = 0;
  int model_retired = 0;

  typedef struct {
    logic [2:0] st;
    logic       mem_read, mem_write, iord, ir_write, pc_write, pc_write_cond;
    logic       reg_write, mem_to_reg, reg_dst, wri_data_sel, alu_src_a;
    logic [1:0] alu_src_b, pc_source;
    logic [5:0] alu_op;
    logic [2:0] flags;
  } exp_t;

  typedef struct {
    logic [5:0] op;
    logic [5:0] fn;
    logic       pc_write;
    logic       reg_write;
    logic [1:0] pc_source;
    logic [2:0] next_st;
    logic       retire;
  } dvec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic exp_t base(input logic [2:0] s);
    exp_t e;
    e.st = s;
    e.mem_read = 0; e.mem_write = 0; e.iord = 0; e.ir_write = 0; e.pc_write = 0;
    e.pc_write_cond = 0; e.reg_write = 0; e.mem_to_reg = 0; e.reg_dst = 0;
    e.wri_data_sel = 0; e.alu_src_a = 0; e.alu_src_b = 2'b00; e.pc_source = 2'b00;
    e.alu_op = A_NOP; e.flags = 3'b000;
    return e;
  endfunction

  function automatic logic [5:0] kind_op(input int k);
    case (k)
      K_XORI: return 6'b001110;
      K_LW:   return 6'b100011;
      K_SW:   return 6'b101011;
      K_J:    return 6'b000010;
      K_JAL:  return 6'b000011;
      K_BNE:  return 6'b000101;
      K_ILL:  return 6'b111111;
      default: return 6'b000000;
    endcase
  endfunction

  function automatic logic [5:0] kind_fn(input int k);
    case (k)
      K_ADD:  return 6'b100000;
      K_SUB:  return 6'b100010;
      K_SLT:  return 6'b101010;
      K_JR:   return 6'b001000;
      K_SYS:  return 6'b001100;
      K_NOOP: return 6'b000000;
      default: return 6'($urandom);
    endcase
  endfunction

  function automatic logic [5:0] exec_alu(input int k);
    case (k)
      K_SUB, K_BNE: return A_SUB;
      K_SLT:        return A_SLT;
      K_XORI:       return A_XOR;
      default:      return A_ADD;
    endcase
  endfunction

  task automatic applyStimulus(input logic rdy, input logic [5:0] op, input logic [5:0] fn);
    mem_ready = rdy;
    opcode    = op;
    funct     = fn;
  endtask

  task automatic checkOutput(input string tag, input exp_t e);
    chk({tag, ".state"},         32'(state),         32'(e.st));
    chk({tag, ".mem_read"},      32'(mem_read),      32'(e.mem_read));
    chk({tag, ".mem_write"},     32'(mem_write),     32'(e.mem_write));
    chk({tag, ".iord"},          32'(iord),          32'(e.iord));
    chk({tag, ".ir_write"},      32'(ir_write),      32'(e.ir_write));
    chk({tag, ".pc_write"},      32'(pc_write),      32'(e.pc_write));
    chk({tag, ".pc_write_cond"}, 32'(pc_write_cond), 32'(e.pc_write_cond));
    chk({tag, ".reg_write"},     32'(reg_write),     32'(e.reg_write));
    chk({tag, ".mem_to_reg"},    32'(mem_to_reg),    32'(e.mem_to_reg));
    chk({tag, ".reg_dst"},       32'(reg_dst),       32'(e.reg_dst));
    chk({tag, ".wri_data_sel"},  32'(wri_data_sel),  32'(e.wri_data_sel));
    chk({tag, ".alu_src_a"},     32'(alu_src_a),     32'(e.alu_src_a));
    chk({tag, ".alu_src_b"},     32'(alu_src_b),     32'(e.alu_src_b));
    chk({tag, ".pc_source"},     32'(pc_source),     32'(e.pc_source));
    chk({tag, ".alu_op"},        32'(alu_op),        32'(e.alu_op));
    chk({tag, ".flags"},         32'({halted, illegal, timeout}), 32'(e.flags));
    chk({tag, ".retired"},       32'(retired),       32'(model_retired % 16));
  endtask

  // One clock: drive at posedge+1, sample at negedge, return at next posedge+1
  task automatic cycle(input logic rdy, input logic [5:0] op, input logic [5:0] fn,
                       input string tag, input exp_t e);
    applyStimulus(rdy, op, fn);
    @(negedge clk);
    checkOutput(tag, e);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    exp_t e;
    reset = 1'b1;
    applyStimulus(1'b1, 6'($urandom), 6'($urandom));
    model_retired = 0;
    @(negedge clk);
    e = base(F);
    e.mem_read = 1;
    checkOutput("reset", e);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // Instruction-level model: the cycle path follows from the instruction class and wait counts
  task automatic run_instr(input int k, input int wf, input int wm, input bit abort_mem);
    exp_t e;
    logic [5:0] op;
    logic [5:0] fn;
    bit rtype;
    op = kind_op(k);
    fn = kind_fn(k);
    rtype = (op == 6'b000000);
    for (int i = 0; i < wf && i < 15; i++) begin
      e = base(F); e.mem_read = 1;
      cycle(1'b0, 6'($urandom), 6'($urandom), "fetch_wait", e);
    end
    if (wf >= 15) begin
      e = base(ER); e.flags = 3'b001;
      cycle(1'b1, 6'($urandom), 6'($urandom), "fetch_timeout", e);
      cycle(1'b1, 6'($urandom), 6'($urandom), "fetch_timeout_sticky", e);
      return;
    end
    e = base(F); e.mem_read = 1; e.ir_write = 1; e.pc_write = 1; e.alu_src_b = 2'b01; e.alu_op = A_ADD;
    cycle(1'b1, 6'($urandom), 6'($urandom), "fetch", e);

    e = base(D); e.alu_src_b = 2'b11; e.alu_op = A_ADD;
    if (k == K_J || k == K_JAL) begin e.pc_write = 1; e.pc_source = 2'b10; end
    if (k == K_JAL) e.reg_write = 1;
    if (k == K_JR) begin e.pc_write = 1; e.pc_source = 2'b11; end
    cycle(1'($urandom), op, fn, "decode", e);
    if (k == K_J || k == K_JAL || k == K_JR || k == K_NOOP) begin
      model_retired++;
      return;
    end
    if (k == K_SYS || k == K_ILL) begin
      e = (k == K_SYS) ? base(H) : base(ER);
      e.flags = (k == K_SYS) ? 3'b100 : 3'b010;
      for (int i = 0; i < 3; i++) cycle(1'($urandom), 6'($urandom), 6'($urandom), "terminal", e);
      return;
    end

    e = base(E); e.alu_src_a = 1; e.alu_op = exec_alu(k);
    if (k == K_XORI || k == K_LW || k == K_SW) e.alu_src_b = 2'b10;
    if (k == K_BNE) begin e.pc_write_cond = 1; e.pc_source = 2'b01; end
    cycle(1'($urandom), 6'($urandom), 6'($urandom), "exec", e);
    if (k == K_BNE) begin
      model_retired++;
      return;
    end

    if (k == K_LW || k == K_SW) begin
      e = base(M); e.iord = 1; e.mem_read = (k == K_LW); e.mem_write = (k == K_SW);
      if (abort_mem) begin
        applyStimulus(1'b0, 6'($urandom), 6'($urandom));
        @(negedge clk);
        checkOutput("mem_pre_reset", e);
        reset = 1'b1;
        mem_ready = 1'b1;
        #1;
        model_retired = 0;
        e = base(F); e.mem_read = 1;
        checkOutput("mem_reset", e);
        @(posedge clk);
        #1;
        @(negedge clk);
        checkOutput("reset_hold", e);
        @(posedge clk);
        #1;
        reset = 1'b0;
        return;
      end
      for (int i = 0; i < wm && i < 15; i++) cycle(1'b0, 6'($urandom), 6'($urandom), "mem_wait", e);
      if (wm >= 15) begin
        e = base(ER); e.flags = 3'b001;
        cycle(1'b1, 6'($urandom), 6'($urandom), "mem_timeout", e);
        return;
      end
      cycle(1'b1, 6'($urandom), 6'($urandom), "mem", e);
      if (k == K_SW) begin
        model_retired++;
        return;
      end
    end

    e = base(W); e.reg_write = 1; e.wri_data_sel = 1; e.reg_dst = rtype; e.mem_to_reg = (k == K_LW);
    cycle(1'($urandom), 6'($urandom), 6'($urandom), "wb", e);
    model_retired++;
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    dvec_t tbl[13];
    exp_t  e;
    tbl[0]  = '{6'b000010, 6'b010101, 1'b1, 1'b0, 2'b10, F,  1'b1};
    tbl[1]  = '{6'b000011, 6'b000000, 1'b1, 1'b1, 2'b10, F,  1'b1};
    tbl[2]  = '{6'b000000, 6'b001000, 1'b1, 1'b0, 2'b11, F,  1'b1};
    tbl[3]  = '{6'b000000, 6'b000000, 1'b0, 1'b0, 2'b00, F,  1'b1};
    tbl[4]  = '{6'b000000, 6'b001100, 1'b0, 1'b0, 2'b00, H,  1'b0};
    tbl[5]  = '{6'b000000, 6'b100000, 1'b0, 1'b0, 2'b00, E,  1'b0};
    tbl[6]  = '{6'b100011, 6'b111000, 1'b0, 1'b0, 2'b00, E,  1'b0};
    tbl[7]  = '{6'b101011, 6'b000000, 1'b0, 1'b0, 2'b00, E,  1'b0};
    tbl[8]  = '{6'b000101, 6'b001100, 1'b0, 1'b0, 2'b00, E,  1'b0};
    tbl[9]  = '{6'b001110, 6'b001000, 1'b0, 1'b0, 2'b00, E,  1'b0};
    tbl[10] = '{6'b111111, 6'b000000, 1'b0, 1'b0, 2'b00, ER, 1'b0};
    tbl[11] = '{6'b000000, 6'b111111, 1'b0, 1'b0, 2'b00, ER, 1'b0};
    tbl[12] = '{6'b000100, 6'b100000, 1'b0, 1'b0, 2'b00, ER, 1'b0};

    reset = 1'b1;
    applyStimulus(1'b0, 6'd0, 6'd0);
    #1;

    for (int i = 0; i < 13; i++) begin
      do_reset();
      e = base(F); e.mem_read = 1; e.ir_write = 1; e.pc_write = 1; e.alu_src_b = 2'b01; e.alu_op = A_ADD;
      cycle(1'b1, 6'($urandom), 6'($urandom), "tbl_fetch", e);
      applyStimulus(1'b1, tbl[i].op, tbl[i].fn);
      @(negedge clk);
      chk($sformatf("tbl%0d.state", i),     32'(state),     32'(D));
      chk($sformatf("tbl%0d.pc_write", i),  32'(pc_write),  32'(tbl[i].pc_write));
      chk($sformatf("tbl%0d.reg_write", i), 32'(reg_write), 32'(tbl[i].reg_write));
      chk($sformatf("tbl%0d.pc_source", i), 32'(pc_source), 32'(tbl[i].pc_source));
      chk($sformatf("tbl%0d.alu_src_b", i), 32'(alu_src_b), 32'(2'b11));
      @(posedge clk);
      #1;
      @(negedge clk);
      chk($sformatf("tbl%0d.next", i),    32'(state),   32'(tbl[i].next_st));
      chk($sformatf("tbl%0d.retired", i), 32'(retired), 32'(tbl[i].retire));
      chk($sformatf("tbl%0d.halted", i),  32'(halted),  32'(tbl[i].next_st == H));
      chk($sformatf("tbl%0d.illegal", i), 32'(illegal), 32'(tbl[i].next_st == ER));
      @(posedge clk);
      #1;
    end

    // ADD with immediate memory, then retired visible as 1
    do_reset();
    run_instr(K_ADD, 0, 0, 1'b0);
    e = base(F); e.mem_read = 1;
    cycle(1'b0, 6'd0, 6'd0, "after_add", e);

    // LW with three wait cycles in MEM, then JAL
    do_reset();
    run_instr(K_LW, 0, 3, 1'b0);
    run_instr(K_JAL, 1, 0, 1'b0);

    // Fetch timeout boundary: completion on the 15th cycle, then a full timeout
    do_reset();
    run_instr(K_XORI, 14, 0, 1'b0);
    run_instr(K_ADD, 15, 0, 1'b0);

    // Memory timeout on a store
    do_reset();
    run_instr(K_SW, 0, 15, 1'b0);

    // SYSCALL halts without retiring; illegal opcode errors; both sticky
    do_reset();
    run_instr(K_ADD, 0, 0, 1'b0);
    run_instr(K_SYS, 0, 0, 1'b0);
    do_reset();
    run_instr(K_ILL, 2, 0, 1'b0);

    // Reset asserted during the MEM cycle of a store
    do_reset();
    run_instr(K_ADD, 0, 0, 1'b0);
    run_instr(K_SW, 0, 0, 1'b1);
    run_instr(K_BNE, 0, 0, 1'b0);

    // Random legal instruction stream; 4-bit retired wraps several times
    do_reset();
    for (int n = 0; n < 80; n++) begin
      int k, wf, wm;
      k  = int'($urandom_range(0, 10));
      wf = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 14)) : int'($urandom_range(0, 2));
      wm = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 14)) : int'($urandom_range(0, 2));
      run_instr(k, wf, wm, 1'b0);
    end
    e = base(F); e.mem_read = 1;
    cycle(1'b0, 6'd0, 6'd0, "final", e);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 Parameters SHALL be: ALUOP_W, default 6, alu_op width (>=6; codes zero-extended); MEM_TIMEOUT, default 15, max consecutive mem_ready-low wait cycles; CNT_W, default 32, retired-counter width.
REQ-002 clk  in  1  single clock; all state changes on rising edge.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 opcode, funct  in  6 each  instruction fields from instruction register.
REQ-005 mem_ready  in  1  memory completes the current access this cycle.
REQ-006 Strobes, out, 1 each: pc_write, pc_write_cond (write PC if ALU zero==0), ir_write, iord, mem_read, mem_write, mem_to_reg, reg_write, reg_dst (1=rd, 0=rt), wri_data_sel (0=PC+4 link to $31, 1=ALU/mem), alu_src_a (0=PC, 1=rs).
REQ-007 alu_src_b, pc_source  out  2 each  B mux (00 rt, 01 const 4, 10 sign-ext imm, 11 imm<<2); PC mux (00 ALU, 01 ALUOut, 10 jump target, 11 rs).
REQ-008 alu_op  out  ALUOP_W  ADD 100000, SUB 100010, XOR 100110, SLT 101010, NOP 101100.
REQ-009 state  out  3  FETCH 0, DECODE 1, EXEC 2, MEM 3, WB 4, HALT 5, ERROR 6.
REQ-010 halted, illegal, timeout  out  1 each  sticky status flags; retired  out  CNT_W  completed-instruction count.

Function
REQ-011 Outputs SHALL be Moore functions of state plus latched opcode/funct and mem_ready; unlisted strobes 0, alu_op NOP.
REQ-012 Opcodes: LW 100011, SW 101011, J 000010, JAL 000011, BNE 000101, XORI 001110, R-type 000000; funct: JR 001000, ADD 100000, SUB 100010, SLT 101010, SYSCALL 001100, NOOP 000000.
REQ-013 FETCH: mem_read=1, iord=0; when mem_ready=1 also ir_write=1, pc_write=1, alu_src_b=01, pc_source=00, alu_op=ADD, next DECODE; else stay.
REQ-014 DECODE: latch opcode/funct; alu_src_b=11, alu_op=ADD (branch target).
REQ-015 DECODE J: pc_write=1, pc_source=10; JAL: same plus reg_write=1, wri_data_sel=0; JR: pc_write=1, pc_source=11; NOOP: no strobes; all four -> FETCH, retired+1.
REQ-016 DECODE SYSCALL -> HALT; undefined opcode or R-type funct -> ERROR with illegal=1; other decodes -> EXEC.
REQ-017 EXEC R-type: alu_src_a=1, alu_src_b=00, alu_op per funct -> WB; XORI: alu_src_a=1, alu_src_b=10, XOR -> WB; LW/SW: alu_src_a=1, alu_src_b=10, ADD -> MEM.
REQ-018 EXEC BNE: alu_src_a=1, alu_src_b=00, SUB, pc_write_cond=1, pc_source=01 -> FETCH, retired+1.
REQ-019 MEM: iord=1, mem_read=1 (LW) or mem_write=1 (SW), held until mem_ready=1; LW -> WB; SW -> FETCH, retired+1.
REQ-020 WB: reg_write=1, wri_data_sel=1; reg_dst=1 R-type, 0 LW/XORI; mem_to_reg=1 only LW -> FETCH, retired+1.
REQ-021 Wait counter SHALL clear on FETCH/MEM entry, increment each mem_ready=0 cycle there; at MEM_TIMEOUT -> ERROR, timeout=1.
REQ-022 mem_ready=1 on the MEM_TIMEOUT-th cycle SHALL complete normally (completion wins).
REQ-023 HALT/ERROR SHALL be absorbing until reset, all strobes 0; halted=1 in HALT.
REQ-024 retired SHALL wrap to 0 past all-ones; SYSCALL and faulting instructions not counted.

Reset
REQ-025 reset=1 SHALL asynchronously force state=FETCH, retired=0, wait counter 0, halted/illegal/timeout=0, latched opcode/funct 0.
REQ-026 Reset mid-instruction SHALL abort it with no further strobes; while reset=1, only FETCH mem_read=1 visible, ir_write/pc_write held 0.

Verification
REQ-027 ADD (000000/100000), mem_ready=1 -> FETCH,DECODE,EXEC,WB; WB reg_write=1, reg_dst=1; retired 0->1 after 4 cycles.
REQ-028 LW, mem_ready low 3 MEM cycles -> MEM held 4 cycles, mem_read=iord=1, then WB mem_to_reg=1, reg_dst=0.
REQ-029 JAL -> DECODE pc_write=1, pc_source=10, reg_write=1, wri_data_sel=0; FETCH 3rd cycle; retired+1.
REQ-030 mem_ready=0 in FETCH, MEM_TIMEOUT=15 -> ERROR 16th cycle, timeout=1; mem_ready=1 at 15th instead -> DECODE.
REQ-031 opcode 111111 -> ERROR, illegal=1; SYSCALL -> HALT, halted=1, retired unchanged; both sticky until reset.
REQ-032 reset pulse during MEM of SW -> mem_write drops immediately, state=FETCH, retired=0.
